// File: rtl/aemb_dwb_sram.sv
// ============================================================================
// aemb_dwb_sram : Wishbone classic word SRAM slave for the AEMB data bus
// Rev 1.0
// ============================================================================
`default_nettype none

module aemb_dwb_sram #(
    parameter int AW   = 12,
    parameter int WAIT = 0
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,
    input  logic          dwb_stb_i,
    input  logic          dwb_wre_i,
    input  logic [3:0]    dwb_sel_i,
    input  logic [AW-3:0] dwb_adr_i,
    input  logic [31:0]   dwb_dat_i,
    output logic          dwb_ack_o,
    output logic [31:0]   dwb_dat_o
);

    localparam int         c_DEPTH = 2 ** (AW - 2);
    localparam logic [3:0] c_WAIT  = WAIT[3:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ACK  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_nxt;
    logic          w_accept;

    logic          r_wre;
    logic [3:0]    r_sel;
    logic [AW-3:0] r_adr;
    logic [31:0]   r_dat;
    logic          r_ack;
    logic [31:0]   r_dat_o;

    logic [AW-3:0] w_rd_adr;
    logic          w_rd_wre;
    logic          w_rd_load;
    logic          w_mem_we;

    logic [31:0]   r_mem [0:c_DEPTH-1];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (dwb_stb_i) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = c_WAIT;
                    w_state_nxt = (c_WAIT == 4'd0) ? S_ACK : S_BUSY;
                end
            end
            S_BUSY: begin
                // Initiator withdrawing the strobe abandons the access outright
                if (!dwb_stb_i) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt <= 4'd1) begin
                    w_state_nxt = S_ACK;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            S_ACK:   w_state_nxt = S_GAP;
            S_GAP:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // With zero wait states the read is served straight from the live inputs
    assign w_rd_adr  = (r_state == S_IDLE) ? dwb_adr_i : r_adr;
    assign w_rd_wre  = (r_state == S_IDLE) ? dwb_wre_i : r_wre;
    assign w_rd_load = (w_state_nxt == S_ACK) && (r_state != S_ACK) && !w_rd_wre;
    assign w_mem_we  = (r_state == S_ACK) && r_wre;

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_ack   <= 1'b0;
            r_dat_o <= 32'd0;
            r_wre   <= 1'b0;
            r_sel   <= 4'd0;
            r_adr   <= '0;
            r_dat   <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= (w_state_nxt == S_ACK);
            if (w_rd_load) begin
                r_dat_o <= r_mem[w_rd_adr];
            end
            if (w_accept) begin
                r_wre <= dwb_wre_i;
                r_sel <= dwb_sel_i;
                r_adr <= dwb_adr_i;
                r_dat <= dwb_dat_i;
            end
        end
    end

    // Storage is deliberately left out of reset; sel[3] is the MSB lane
    always_ff @(posedge sys_clk_i) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (r_sel[i]) begin
                    r_mem[r_adr][8*i +: 8] <= r_dat[8*i +: 8];
                end
            end
        end
    end

    assign dwb_ack_o = r_ack;
    assign dwb_dat_o = r_dat_o;

endmodule

`default_nettype wire

// File: tb/tb_aemb_dwb_sram.sv
// ============================================================================
// tb_aemb_dwb_sram : randomized self-checking bench, WAIT=0 and WAIT=3 slaves
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_aemb_dwb_sram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb [2];
    logic        wre [2];
    logic [3:0]  sel [2];
    logic [9:0]  adr [2];
    logic [31:0] dat [2];
    wire         ack0, ack1;
    wire  [31:0] dato0, dato1;

    int          ncmp = 0;
    int          nerr = 0;
    int          n_req = 0;
    int          n_pulse = 0;
    int          waits [2];
    logic [31:0] model [2][1024];
    bit          valid [2][1024];
    logic [31:0] last_rd [2];

    always #5 clk = ~clk;

    aemb_dwb_sram #(.AW(12), .WAIT(0)) u_dut0 (
        .sys_clk_i (clk),    .sys_rst_i (rst_n),
        .dwb_stb_i (stb[0]), .dwb_wre_i (wre[0]), .dwb_sel_i (sel[0]),
        .dwb_adr_i (adr[0]), .dwb_dat_i (dat[0]),
        .dwb_ack_o (ack0),   .dwb_dat_o (dato0)
    );

    aemb_dwb_sram #(.AW(12), .WAIT(3)) u_dut1 (
        .sys_clk_i (clk),    .sys_rst_i (rst_n),
        .dwb_stb_i (stb[1]), .dwb_wre_i (wre[1]), .dwb_sel_i (sel[1]),
        .dwb_adr_i (adr[1]), .dwb_dat_i (dat[1]),
        .dwb_ack_o (ack1),   .dwb_dat_o (dato1)
    );

    always @(negedge clk) begin
        if (rst_n) n_pulse += int'(ack0) + int'(ack1);
    end

    function automatic logic get_ack(input int u);
        return (u == 0) ? ack0 : ack1;
    endfunction

    function automatic logic [31:0] get_dat(input int u);
        return (u == 0) ? dato0 : dato1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full Wishbone transaction; inputs are scrambled once accepted
    task automatic do_access(input int u, input bit we, input logic [9:0] a,
                             input logic [3:0] s, input logic [31:0] d,
                             output logic [31:0] rd);
        int          lat;
        logic [31:0] snap;
        logic [31:0] m;
        @(negedge clk);
        stb[u] = 1'b1; wre[u] = we; sel[u] = s; adr[u] = a; dat[u] = d;
        n_req++;
        lat  = 0;
        snap = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (get_ack(u)) begin
                lat  = k;
                snap = get_dat(u);
            end
            wre[u] = 1'($urandom());
            sel[u] = 4'($urandom());
            adr[u] = 10'($urandom());
            dat[u] = $urandom();
            if (lat != 0) break;
        end
        check(we ? "wr_latency" : "rd_latency", lat, waits[u] + 1);
        if (we) begin
            check("wr_dato_hold", snap, last_rd[u]);
            m = model[u][a];
            for (int i = 0; i < 4; i++)
                if (s[i]) m[8*i +: 8] = d[8*i +: 8];
            model[u][a] = m;
            if (s == 4'hF) valid[u][a] = 1'b1;
        end else begin
            if (valid[u][a]) begin
                check("rd_data", snap, model[u][a]);
                last_rd[u] = model[u][a];
            end else begin
                last_rd[u] = snap;
            end
        end
        rd = snap;
        @(negedge clk);
        check("gap_no_ack", get_ack(u), 1'b0);
        stb[u] = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        seen;
        int          u;
        waits[0] = 0;
        waits[1] = 3;
        for (int i = 0; i < 2; i++) begin
            stb[i] = 1'b0; wre[i] = 1'b0; sel[i] = 4'h0; adr[i] = '0; dat[i] = '0;
            last_rd[i] = 32'd0;
            for (int j = 0; j < 1024; j++) begin
                model[i][j] = 32'd0;
                valid[i][j] = 1'b0;
            end
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ack0", ack0, 1'b0);
        check("reset_ack1", ack1, 1'b0);
        check("reset_dato0", dato0, 32'd0);
        check("reset_dato1", dato1, 32'd0);
        rst_n = 1'b1;

        // Zero-wait write then read
        do_access(0, 1'b1, 10'h004, 4'hF, 32'hDEADBEEF, rd);
        do_access(0, 1'b0, 10'h004, 4'h0, 32'h0, rd);
        check("t1_read", rd, 32'hDEADBEEF);

        // Single byte-lane write
        do_access(0, 1'b1, 10'h020, 4'hF, 32'h11223344, rd);
        do_access(0, 1'b1, 10'h020, 4'b0100, 32'hAABBCCDD, rd);
        do_access(0, 1'b0, 10'h020, 4'h3, 32'h0, rd);
        check("t2_lane", rd, 32'h11BB3344);

        // Three wait states
        do_access(1, 1'b1, 10'h030, 4'hF, 32'h12345678, rd);
        do_access(1, 1'b0, 10'h030, 4'hF, 32'h0, rd);

        // Abort during BUSY
        @(negedge clk);
        stb[1] = 1'b1; wre[1] = 1'b1; sel[1] = 4'hF; adr[1] = 10'h030; dat[1] = 32'hCAFEF00D;
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen = seen | ack1;
        end
        stb[1] = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | ack1;
        end
        check("abort_no_ack", seen, 1'b0);
        do_access(1, 1'b0, 10'h030, 4'hF, 32'h0, rd);
        check("abort_keep", rd, 32'h12345678);

        // Reset in the middle of a write
        do_access(1, 1'b1, 10'h040, 4'hF, 32'h0BADF00D, rd);
        do_access(1, 1'b0, 10'h040, 4'hF, 32'h0, rd);
        @(negedge clk);
        stb[1] = 1'b1; wre[1] = 1'b1; sel[1] = 4'hF; adr[1] = 10'h040; dat[1] = 32'hFFFFFFFF;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_ack", ack1, 1'b0);
        check("rst_mid_dato", dato1, 32'd0);
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        @(negedge clk);
        stb[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | ack1;
        end
        check("rst_no_ack", seen, 1'b0);
        do_access(1, 1'b0, 10'h040, 4'hF, 32'h0, rd);
        check("rst_keep", rd, 32'h0BADF00D);

        // Empty-lane write leaves the word untouched
        do_access(0, 1'b1, 10'h004, 4'h0, 32'h55555555, rd);
        do_access(0, 1'b0, 10'h004, 4'hF, 32'h0, rd);
        check("sel0_keep", rd, 32'hDEADBEEF);

        // Randomised back-to-back traffic over words 0..7 on both slaves
        for (int a = 0; a < 8; a++) begin
            do_access(0, 1'b1, 10'(a), 4'hF, $urandom(), rd);
            do_access(1, 1'b1, 10'(a), 4'hF, $urandom(), rd);
        end
        for (int a = 0; a < 8; a++) begin
            u = int'($urandom_range(1, 0));
            do_access(u, 1'b1, 10'(a), 4'($urandom()), $urandom(), rd);
        end
        for (int a = 0; a < 8; a++) begin
            do_access(0, 1'b0, 10'(a), 4'($urandom()), $urandom(), rd);
            do_access(1, 1'b0, 10'(a), 4'($urandom()), $urandom(), rd);
        end

        repeat (3) @(negedge clk);
        check("ack_count", n_pulse, n_req);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

`default_nettype wire
